// File: rtl/fpadd_arbiter_if.sv
// Handshake bundle around fpadd_arbiter: two requester ports, the shared adder
// hookup, and two response ports.
interface fpadd_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_out;
    logic        rsp0_valid;
    logic        rsp0_ready;
    logic [31:0] rsp0_data;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [31:0] rsp1_data;
    logic        busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        input  add_out, rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready, add_a, add_b,
        output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        output add_out, rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready, add_a, add_b,
        input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data, busy
    );
endinterface

// File: rtl/fpadd_arbiter.sv
// Round-robin front end sharing one pipelined FP32 adder between two requesters,
// with credit-reserved per-requester response FIFOs so results are never dropped.
module fpadd_arbiter #(
    parameter int ADD_LAT   = 2,
    parameter int RSP_DEPTH = 4
) (
    input logic            clk,
    input logic            reset,
    fpadd_arbiter_if.slave bus
);
    localparam int AW = $clog2(RSP_DEPTH);
    localparam int CW = AW + 1;

    logic          req_valid [2];
    logic [31:0]   req_a     [2];
    logic [31:0]   req_b     [2];
    logic          rsp_ready [2];

    logic [CW-1:0] count     [2];
    logic [CW-1:0] inflight  [2];
    logic [CW-1:0] credit    [2];
    logic [AW-1:0] wr_ptr    [2];
    logic [AW-1:0] rd_ptr    [2];
    logic [31:0]   mem       [2][RSP_DEPTH];

    logic          elig      [2];
    logic          grant     [2];
    logic          push      [2];
    logic          pop       [2];
    logic          last_grant;

    logic [ADD_LAT-1:0] vld_p;
    logic [ADD_LAT-1:0] id_p;

    assign req_valid[0] = bus.req0_valid;
    assign req_valid[1] = bus.req1_valid;
    assign req_a[0]     = bus.req0_a;
    assign req_a[1]     = bus.req1_a;
    assign req_b[0]     = bus.req0_b;
    assign req_b[1]     = bus.req1_b;
    assign rsp_ready[0] = bus.rsp0_ready;
    assign rsp_ready[1] = bus.rsp1_ready;

    // Credits count FIFO slots plus results still in the adder, so a grant always has a home.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            credit[i] = CW'(RSP_DEPTH) - count[i] - inflight[i];
            elig[i]   = req_valid[i] && (credit[i] != '0);
            pop[i]    = (count[i] != '0) && rsp_ready[i];
        end
        grant[0] = elig[0] && (!elig[1] || last_grant);
        grant[1] = elig[1] && (!elig[0] || !last_grant);
        push[0]  = vld_p[ADD_LAT-1] && !id_p[ADD_LAT-1];
        push[1]  = vld_p[ADD_LAT-1] &&  id_p[ADD_LAT-1];
    end

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];
    assign bus.add_a = grant[0] ? req_a[0] : (grant[1] ? req_a[1] : '0);
    assign bus.add_b = grant[0] ? req_b[0] : (grant[1] ? req_b[1] : '0);

    assign bus.rsp0_valid = (count[0] != '0);
    assign bus.rsp1_valid = (count[1] != '0);
    assign bus.rsp0_data  = (count[0] != '0) ? mem[0][rd_ptr[0]] : '0;
    assign bus.rsp1_data  = (count[1] != '0) ? mem[1][rd_ptr[1]] : '0;
    assign bus.busy       = (|vld_p) || (count[0] != '0) || (count[1] != '0);

    // Stage p0..p(ADD_LAT-1): tag pipeline tracking which requester owns add_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
            vld_p      <= '0;
            for (int i = 0; i < 2; i++) begin
                count[i]    <= '0;
                inflight[i] <= '0;
                wr_ptr[i]   <= '0;
                rd_ptr[i]   <= '0;
            end
        end else begin
            if (grant[0] || grant[1])
                last_grant <= grant[1];
            vld_p[0] <= grant[0] || grant[1];
            for (int s = 1; s < ADD_LAT; s++)
                vld_p[s] <= vld_p[s-1];
            for (int i = 0; i < 2; i++) begin
                count[i]    <= count[i] + CW'(push[i]) - CW'(pop[i]);
                inflight[i] <= inflight[i] + CW'(grant[i]) - CW'(push[i]);
                wr_ptr[i]   <= wr_ptr[i] + AW'(push[i]);
                rd_ptr[i]   <= rd_ptr[i] + AW'(pop[i]);
            end
        end
    end

    // Result landing stage: add_out captured into the owning FIFO.
    always_ff @(posedge clk) begin
        id_p[0] <= grant[1];
        for (int s = 1; s < ADD_LAT; s++)
            id_p[s] <= id_p[s-1];
        for (int i = 0; i < 2; i++)
            if (push[i])
                mem[i][wr_ptr[i]] <= bus.add_out;
    end
endmodule
